// File: rtl/branch_pkg.sv
`default_nettype none
// ============================================================================
// Module  : branch_pkg
// Purpose : Shared types and helpers for the EX-stage branch resolver.
//           Provides the branch funct3 encodings, the 2-bit BHT counter type,
//           the resolver FSM states, the BHT reset value and the saturating
//           counter update.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package branch_pkg;

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } funct3_e;

  typedef logic [1:0] bht_cnt_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } br_state_e;

  // Weak not-taken: one taken outcome flips the prediction.
  localparam bht_cnt_t BHT_INIT = 2'b01;

  // Saturating 2-bit counter step toward the resolved outcome.
  function automatic bht_cnt_t bht_next(input bht_cnt_t cur, input logic taken);
    if (taken) begin
      return (cur == 2'b11) ? cur : cur + 2'd1;
    end
    return (cur == 2'b00) ? cur : cur - 2'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bht_2bit.sv
`default_nettype none
// ============================================================================
// Module  : bht_2bit
// Purpose : Branch history table of 2-bit saturating counters.
//           Two asynchronous read ports (fetch lookup, EX read-modify-write)
//           and one synchronous write port. Synchronous reset loads every
//           entry with BHT_INIT. A read of an index being written in the same
//           cycle returns the old value.
// Ports   : clk, rst          - clock, synchronous active-high reset
//           rd_idx_a/rd_cnt_a - read port A (fetch prediction)
//           rd_idx_b/rd_cnt_b - read port B (EX current counter)
//           we/wr_idx/wr_cnt  - write port
// Revision: 1.0 - initial release
// ============================================================================
module bht_2bit
  import branch_pkg::*;
#(
  parameter int BHT_ENTRIES = 64,
  localparam int IW = $clog2(BHT_ENTRIES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] rd_idx_a,
  output bht_cnt_t      rd_cnt_a,
  input  logic [IW-1:0] rd_idx_b,
  output bht_cnt_t      rd_cnt_b,
  input  logic          we,
  input  logic [IW-1:0] wr_idx,
  input  bht_cnt_t      wr_cnt
);

  bht_cnt_t entries [BHT_ENTRIES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        entries[i] <= BHT_INIT;
      end
    end else if (we) begin
      entries[wr_idx] <= wr_cnt;
    end
  end

  assign rd_cnt_a = entries[rd_idx_a];
  assign rd_cnt_b = entries[rd_idx_b];

endmodule
`default_nettype wire

// File: rtl/branch_resolve.sv
`default_nettype none
// ============================================================================
// Module  : branch_resolve
// Purpose : EX-stage branch resolution. Turns BrEq/BrLt and funct3 into a
//           taken decision, compares it with the fetch prediction, issues a
//           registered redirect and a multi-cycle IF/ID flush on mispredict,
//           and trains a 2-bit BHT that fetch reads for prediction.
// Config  : define BR_PERF_EN to add branch_cnt_o / mispred_cnt_o counters.
// Ports   : clk_i, rst_i        - clock, synchronous active-high reset
//           valid_i, stall_i    - EX instruction valid / EX stalled
//           is_branch_i         - conditional branch in EX
//           is_jump_i           - JAL/JALR in EX (always taken)
//           funct3_i            - branch condition select
//           BrEq_i, BrLt_i      - comparator results; BrUn_o selects unsigned
//           pc_i, target_i      - EX PC and computed target
//           pred_taken_i        - prediction made at fetch
//           redirect_o          - one-cycle pulse, fetch loads redirect_pc_o
//           redirect_pc_o       - corrected PC (held until next mispredict)
//           flush_o             - kill IF/ID contents
//           if_pc_i             - fetch PC for BHT lookup
//           if_pred_taken_o     - BHT prediction for if_pc_i
//           branch_cnt_o        - (BR_PERF_EN) resolved branches+jumps
//           mispred_cnt_o       - (BR_PERF_EN) mispredicts
// Revision: 1.0 - initial release
// ============================================================================
module branch_resolve
  import branch_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int BHT_ENTRIES  = 64,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  input  logic            stall_i,
  input  logic            is_branch_i,
  input  logic            is_jump_i,
  input  logic [2:0]      funct3_i,
  input  logic            BrEq_i,
  input  logic            BrLt_i,
  output logic            BrUn_o,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] target_i,
  input  logic            pred_taken_i,
  output logic            redirect_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic            flush_o,
  input  logic [XLEN-1:0] if_pc_i,
  output logic            if_pred_taken_o
`ifdef BR_PERF_EN
  ,
  output logic [31:0]     branch_cnt_o,
  output logic [31:0]     mispred_cnt_o
`endif
);

  localparam int IW = $clog2(BHT_ENTRIES);
  // Counter holds FLUSH_CYCLES-1 down to 0.
  localparam int CW = $clog2(FLUSH_CYCLES + 1);

  br_state_e         state;
  br_state_e         state_next;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_next;
  logic              redirect_q;
  logic [XLEN-1:0]   redirect_pc_q;

  logic              cond_taken;
  logic              f3_legal;
  logic              fire;
  logic              resolved_taken;
  logic              mispredict;
  logic              bht_we;
  bht_cnt_t          ex_cnt;
  bht_cnt_t          if_cnt;

  // Only the index bits of the fetch PC address the table.
  logic              unused_if_pc;
  assign unused_if_pc = ^{if_pc_i[XLEN-1:IW+2], if_pc_i[1:0]};

  // --------------------------------------------------------------------------
  // Condition decode
  // --------------------------------------------------------------------------
  assign BrUn_o = funct3_i[1];

  always_comb begin
    cond_taken = 1'b0;
    f3_legal   = 1'b1;
    case (funct3_i)
      F3_BEQ:          cond_taken = BrEq_i;
      F3_BNE:          cond_taken = ~BrEq_i;
      F3_BLT, F3_BLTU: cond_taken = BrLt_i;
      F3_BGE, F3_BGEU: cond_taken = ~BrLt_i;
      default:         f3_legal   = 1'b0;
    endcase
  end

  // flush_o gates fire, so nothing in EX resolves while IF/ID is being killed
  // and a mispredict can never re-trigger the flush.
  assign fire           = valid_i & ~stall_i & ~flush_o;
  assign resolved_taken = is_jump_i | cond_taken;
  assign mispredict     = fire & ((is_branch_i & (cond_taken != pred_taken_i)) |
                                  (is_jump_i & ~pred_taken_i));
  assign bht_we         = fire & is_branch_i & f3_legal;

  // --------------------------------------------------------------------------
  // Flush FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (mispredict) begin
          state_next = FLUSH;
          cnt_next   = CW'(FLUSH_CYCLES - 1);
        end
      end
      FLUSH: begin
        if (cnt == '0) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_comb begin
    flush_o = (state == FLUSH);
  end

  // --------------------------------------------------------------------------
  // Redirect registers: pulse on the FSM's first FLUSH cycle, PC held after.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      redirect_q <= mispredict;
      if (mispredict) begin
        redirect_pc_q <= resolved_taken ? target_i : pc_i + XLEN'(4);
      end
    end
  end

  assign redirect_o    = redirect_q;
  assign redirect_pc_o = redirect_pc_q;

  // --------------------------------------------------------------------------
  // Branch history table
  // --------------------------------------------------------------------------
  bht_2bit #(
    .BHT_ENTRIES (BHT_ENTRIES)
  ) u_bht (
    .clk      (clk_i),
    .rst      (rst_i),
    .rd_idx_a (if_pc_i[IW+1:2]),
    .rd_cnt_a (if_cnt),
    .rd_idx_b (pc_i[IW+1:2]),
    .rd_cnt_b (ex_cnt),
    .we       (bht_we),
    .wr_idx   (pc_i[IW+1:2]),
    .wr_cnt   (bht_next(ex_cnt, cond_taken))
  );

  assign if_pred_taken_o = if_cnt[1];

  // --------------------------------------------------------------------------
  // Optional performance counters
  // --------------------------------------------------------------------------
`ifdef BR_PERF_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      branch_cnt_o  <= '0;
      mispred_cnt_o <= '0;
    end else begin
      if (fire & (is_branch_i | is_jump_i)) begin
        branch_cnt_o <= branch_cnt_o + 32'd1;
      end
      if (mispredict) begin
        mispred_cnt_o <= mispred_cnt_o + 32'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve.sv
`default_nettype none
// ============================================================================
// Module  : tb_branch_resolve
// Purpose : Self-checking bench for branch_resolve: a decode vector table,
//           directed multi-cycle sequences and randomized traffic, all
//           checked against a behavioural reference model.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_branch_resolve;

  localparam int XLEN         = 32;
  localparam int BHT_ENTRIES  = 64;
  localparam int FLUSH_CYCLES = 2;
  localparam int IW           = 6;

  logic        clk = 1'b0;
  logic        rst, valid, stall, is_branch, is_jump, breq, brlt, pred;
  logic [2:0]  funct3;
  logic [31:0] pc, target, if_pc;
  logic        brun, redirect, flush, if_pred;
  logic [31:0] redirect_pc;
`ifdef BR_PERF_EN
  logic [31:0] branch_cnt, mispred_cnt;
`endif

  always #5 clk = ~clk;

  branch_resolve #(
    .XLEN(XLEN), .BHT_ENTRIES(BHT_ENTRIES), .FLUSH_CYCLES(FLUSH_CYCLES)
  ) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .stall_i(stall),
    .is_branch_i(is_branch), .is_jump_i(is_jump), .funct3_i(funct3),
    .BrEq_i(breq), .BrLt_i(brlt), .BrUn_o(brun), .pc_i(pc),
    .target_i(target), .pred_taken_i(pred), .redirect_o(redirect),
    .redirect_pc_o(redirect_pc), .flush_o(flush), .if_pc_i(if_pc),
    .if_pred_taken_o(if_pred)
`ifdef BR_PERF_EN
    , .branch_cnt_o(branch_cnt), .mispred_cnt_o(mispred_cnt)
`endif
  );

  // ---------------- reference model ----------------
  int          m_bht [BHT_ENTRIES];
  int          m_flush_left;
  logic        m_redirect;
  logic [31:0] m_rpc;
  logic [31:0] m_bcnt, m_mcnt;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit ref_taken(input logic [2:0] f3, input logic eq, input logic lt);
    case (f3)
      3'd0:       return eq;
      3'd1:       return !eq;
      3'd4, 3'd6: return lt;
      3'd5, 3'd7: return !lt;
      default:    return 1'b0;
    endcase
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 2) % BHT_ENTRIES);
  endfunction

  task automatic model_reset();
    m_flush_left = 0;
    m_redirect   = 1'b0;
    m_rpc        = 32'd0;
    m_bcnt       = 32'd0;
    m_mcnt       = 32'd0;
    for (int i = 0; i < BHT_ENTRIES; i++) m_bht[i] = 1;
  endtask

  task automatic model_step();
    bit fire, tk, legal, mp;
    if (rst) begin
      model_reset();
      return;
    end
    fire  = valid && !stall && (m_flush_left == 0);
    tk    = ref_taken(funct3, breq, brlt);
    legal = (funct3 != 3'd2) && (funct3 != 3'd3);
    mp    = fire && ((is_branch && (tk != pred)) || (is_jump && !pred));
    if (fire && (is_branch || is_jump)) m_bcnt = m_bcnt + 1;
    if (mp) m_mcnt = m_mcnt + 1;
    if (mp) m_rpc = (is_jump || tk) ? target : pc + 32'd4;
    m_redirect = mp;
    if (fire && is_branch && legal) begin
      if (tk) m_bht[idx_of(pc)] = (m_bht[idx_of(pc)] == 3) ? 3 : m_bht[idx_of(pc)] + 1;
      else    m_bht[idx_of(pc)] = (m_bht[idx_of(pc)] == 0) ? 0 : m_bht[idx_of(pc)] - 1;
    end
    m_flush_left = mp ? FLUSH_CYCLES : ((m_flush_left > 0) ? m_flush_left - 1 : 0);
  endtask

  // Check all outputs against the model at the falling edge, then advance
  // the model through the rising edge. Returns 1 time unit after the edge.
  task automatic cycle();
    @(negedge clk);
    check("brun",        {31'd0, brun},     {31'd0, funct3[1]});
    check("if_pred",     {31'd0, if_pred},  {31'd0, m_bht[idx_of(if_pc)] >= 2});
    check("flush",       {31'd0, flush},    {31'd0, m_flush_left > 0});
    check("redirect",    {31'd0, redirect}, {31'd0, m_redirect});
    check("redirect_pc", redirect_pc,       m_rpc);
`ifdef BR_PERF_EN
    check("branch_cnt",  branch_cnt,        m_bcnt);
    check("mispred_cnt", mispred_cnt,       m_mcnt);
`endif
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid = 0; is_branch = 0; is_jump = 0; stall = 0;
  endtask

  task automatic br(input logic [2:0] f3, input logic eq, input logic lt,
                    input logic p, input logic [31:0] a, input logic [31:0] t);
    valid = 1; is_branch = 1; is_jump = 0; stall = 0;
    funct3 = f3; breq = eq; brlt = lt; pred = p; pc = a; target = t;
  endtask

  // ---------------- decode vector table ----------------
  typedef struct {
    logic [2:0]  f3;
    logic        eq, lt, p;
    logic        exp_brun;
    logic        exp_redir;
    logic [31:0] exp_rpc;
  } vec_t;

  vec_t vecs [10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{3'b000, 1, 0, 0, 0, 1, 32'h300};
    vecs[1] = '{3'b000, 0, 0, 0, 0, 0, 32'h0};
    vecs[2] = '{3'b001, 0, 0, 0, 0, 1, 32'h300};
    vecs[3] = '{3'b001, 1, 0, 1, 0, 1, 32'h204};
    vecs[4] = '{3'b100, 0, 1, 1, 0, 0, 32'h0};
    vecs[5] = '{3'b101, 0, 1, 1, 0, 1, 32'h204};
    vecs[6] = '{3'b110, 0, 1, 0, 1, 1, 32'h300};
    vecs[7] = '{3'b111, 0, 0, 1, 1, 0, 32'h0};
    vecs[8] = '{3'b010, 1, 0, 0, 1, 0, 32'h0};
    vecs[9] = '{3'b011, 0, 1, 0, 1, 0, 32'h0};

    rst = 1; idle(); funct3 = 0; breq = 0; brlt = 0; pred = 0;
    pc = 0; target = 0; if_pc = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    cycle();                      // reset state observed
    rst = 0;
    cycle();

    // Decode table
    for (int i = 0; i < 10; i++) begin
      br(vecs[i].f3, vecs[i].eq, vecs[i].lt, vecs[i].p, 32'h200, 32'h300);
      #1;
      check("tbl_brun", {31'd0, brun}, {31'd0, vecs[i].exp_brun});
      cycle();
      idle();
      check("tbl_redirect", {31'd0, redirect}, {31'd0, vecs[i].exp_redir});
      if (vecs[i].exp_redir) check("tbl_rpc", redirect_pc, vecs[i].exp_rpc);
      repeat (3) cycle();
    end

    // Rst to get a clean BHT for the directed sequences
    rst = 1; cycle(); rst = 0; cycle();

    // Seq 1: BEQ mispredict taken
    br(3'b000, 1, 0, 0, 32'h100, 32'h80);
    cycle(); idle();
    check("s1_redirect", {31'd0, redirect}, 32'd1);
    check("s1_rpc", redirect_pc, 32'h80);
    check("s1_flush_a", {31'd0, flush}, 32'd1);
    cycle();
    check("s1_redirect_pulse", {31'd0, redirect}, 32'd0);
    check("s1_flush_b", {31'd0, flush}, 32'd1);
    cycle();
    check("s1_flush_end", {31'd0, flush}, 32'd0);
    check("s1_rpc_hold", redirect_pc, 32'h80);

    // Seq 2: BLTU not taken, correctly predicted -> BHT 01->00
    br(3'b110, 0, 0, 0, 32'h140, 32'h0);
    if_pc = 32'h140;
    #1;
    check("s2_brun", {31'd0, brun}, 32'd1);
    cycle();
    check("s2_no_redirect", {31'd0, redirect}, 32'd0);
    br(3'b110, 0, 1, 1, 32'h140, 32'h40);   // one taken update: 00->01
    cycle(); idle();
    check("s2_bht_after", {31'd0, if_pred}, 32'd0);
    cycle();

    // Seq 3: BNE not taken at top of memory -> pc+4 wraps
    br(3'b001, 1, 0, 1, 32'hFFFF_FFFC, 32'h1234);
    cycle(); idle();
    check("s3_redirect", {31'd0, redirect}, 32'd1);
    check("s3_rpc_wrap", redirect_pc, 32'h0);
    repeat (2) cycle();

    // Seq 4: second mispredict during FLUSH is ignored
    br(3'b000, 1, 0, 0, 32'h400, 32'h500);
    cycle();
    br(3'b000, 1, 0, 0, 32'h404, 32'h600);
    if_pc = 32'h404;
    cycle(); idle();
    check("s4_no_second", {31'd0, redirect}, 32'd0);
    check("s4_rpc_kept", redirect_pc, 32'h500);
    cycle();
    check("s4_redirect_off", {31'd0, redirect}, 32'd0);
    check("s4_bht_untouched", {31'd0, if_pred}, 32'd0);

    // Seq 5: saturation 01->10->11->11, then back down
    if_pc = 32'h8A0;
    for (int k = 0; k < 3; k++) begin
      br(3'b000, 1, 0, 1, 32'h8A0, 32'h900);
      cycle();
      if (k >= 1) check("s5_pred_taken", {31'd0, if_pred}, 32'd1);
    end
    br(3'b000, 0, 0, 0, 32'h8A0, 32'h900);   // 11->10
    cycle();
    check("s5_saturated", {31'd0, if_pred}, 32'd1);
    cycle();                                 // 10->01
    idle();
    check("s5_down", {31'd0, if_pred}, 32'd0);
    cycle();

    // Seq 6: reset in the first FLUSH cycle
    br(3'b100, 0, 1, 0, 32'h8A0, 32'hA00);   // taken, also trains idx to 10
    cycle(); idle();
    rst = 1;
    cycle();
    rst = 0;
    check("s6_flush", {31'd0, flush}, 32'd0);
    check("s6_redirect", {31'd0, redirect}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      if_pc = (k == 0) ? 32'h8A0 : $urandom;
      #1;
      check("s6_bht_reset", {31'd0, if_pred}, 32'd0);
    end
    cycle();

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      rst       = ($urandom_range(0, 199) == 0);
      valid     = ($urandom_range(0, 9) < 7);
      stall     = ($urandom_range(0, 4) == 0);
      is_jump   = ($urandom_range(0, 7) == 0);
      is_branch = !is_jump && ($urandom_range(0, 9) < 8);
      funct3    = 3'($urandom_range(0, 7));
      breq      = 1'($urandom);
      brlt      = 1'($urandom);
      pred      = 1'($urandom);
      pc        = ($urandom & 32'hFFFF_FF00) | (32'($urandom_range(0, 7)) << 2);
      target    = $urandom & 32'hFFFF_FFFC;
      if_pc     = ($urandom_range(0, 1) == 1) ? pc : (32'($urandom_range(0, 7)) << 2);
      cycle();
    end
    rst = 0; idle();
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
